// File: rtl/pulse_stretcher_out.sv
// Output pulse stretcher: turns single-cycle event strobes into fixed-width pulses
// with a guaranteed gap, replaying events that arrive mid-pulse from a saturating queue.
module pulse_stretcher_out #(
    parameter int unsigned HOLD_CYCLES = 200,
    parameter int unsigned GAP_CYCLES  = 50,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PEND_W      = 4,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trig_in,
    input  logic              clear,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap
    } state_e;

    localparam logic [CNT_W-1:0]  HoldLoad = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  GapLoad  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PendOne  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PendMax  = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              pulse_q;
    logic              busy_q;

    logic start;
    logic take;
    logic take_idle;
    logic consume;
    logic enqueue;
    logic pend_nz;

    assign pend_nz = (pend_q != '0);
    assign start   = trig_in | pend_nz;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take      = 1'b0;
        take_idle = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StActive;
                    cnt_d     = HoldLoad;
                    take      = 1'b1;
                    take_idle = 1'b1;
                end
            end
            StActive: begin
                if (cnt_q == CntOne) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap: begin
                // Last gap cycle can chain straight into the next pulse.
                if (cnt_q == CntOne) begin
                    if (start) begin
                        state_d = StActive;
                        cnt_d   = HoldLoad;
                        take    = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // A trigger that directly starts a pulse from an empty idle queue is not queued.
    assign consume = take & pend_nz;
    assign enqueue = trig_in & ~(take_idle & ~pend_nz);

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (enqueue && !consume) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PendOne;
            end
        end else if (!enqueue && consume) begin
            pend_d = pend_q - PendOne;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= ACTIVE_LOW;
            busy_q  <= 1'b0;
        end else if (clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= ACTIVE_LOW;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            pulse_q <= (state_d == StActive) ^ ACTIVE_LOW;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher_out.sv
// Randomised and directed bench for pulse_stretcher_out; an active-high and an
// active-low instance share stimulus and are checked against a timeline model.
module tb_pulse_stretcher_out;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int PW   = 2;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          trig_in = 1'b0;
    logic          clear = 1'b0;
    logic          pulse_hi, busy_hi, ovf_hi;
    logic          pulse_lo, busy_lo, ovf_lo;
    logic [PW-1:0] pend_hi, pend_lo;

    always #5 clk = ~clk;

    pulse_stretcher_out #(
        .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(16), .PEND_W(PW), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .reset_n(reset_n), .trig_in(trig_in), .clear(clear),
        .pulse_out(pulse_hi), .busy(busy_hi), .pending(pend_hi), .overflow(ovf_hi)
    );

    pulse_stretcher_out #(
        .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(16), .PEND_W(PW), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk(clk), .reset_n(reset_n), .trig_in(trig_in), .clear(clear),
        .pulse_out(pulse_lo), .busy(busy_lo), .pending(pend_lo), .overflow(ovf_lo)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: cycles elapsed since the current pulse started (-1 when idle).
    int m_since = -1;
    int m_pend  = 0;
    bit m_ovf   = 1'b0;

    int rises = 0;
    bit prev_pulse = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_since = -1;
        m_pend  = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_edge(input bit t, input bit c);
        bit can, start, take, consume, enq;
        if (c) begin
            model_reset();
            return;
        end
        can     = (m_since < 0) || (m_since == H + G - 1);
        start   = t || (m_pend > 0);
        take    = can && start;
        consume = take && (m_pend > 0);
        enq     = t && !(take && (m_since < 0) && (m_pend == 0));
        if (enq && !consume) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
        end else if (!enq && consume) begin
            m_pend--;
        end
        if (take) m_since = 0;
        else if (m_since >= 0) begin
            m_since++;
            if (m_since >= H + G) m_since = -1;
        end
    endfunction

    task automatic check_all(input string tag);
        bit act;
        act = (m_since >= 0) && (m_since < H);
        check_eq({tag, ".pulse_hi"}, 32'(pulse_hi), 32'(act));
        check_eq({tag, ".pulse_lo"}, 32'(pulse_lo), 32'(!act));
        check_eq({tag, ".busy_hi"}, 32'(busy_hi), 32'(m_since >= 0));
        check_eq({tag, ".busy_lo"}, 32'(busy_lo), 32'(m_since >= 0));
        check_eq({tag, ".pend_hi"}, 32'(pend_hi), 32'(m_pend));
        check_eq({tag, ".pend_lo"}, 32'(pend_lo), 32'(m_pend));
        check_eq({tag, ".ovf_hi"}, 32'(ovf_hi), 32'(m_ovf));
        check_eq({tag, ".ovf_lo"}, 32'(ovf_lo), 32'(m_ovf));
    endtask

    // Inputs are applied at the falling edge, outputs sampled at the next falling edge.
    task automatic step(input string tag, input bit t, input bit c);
        trig_in = t;
        clear   = c;
        @(posedge clk);
        model_edge(t, c);
        @(negedge clk);
        trig_in = 1'b0;
        clear   = 1'b0;
        check_all(tag);
        if (pulse_hi && !prev_pulse) rises++;
        prev_pulse = pulse_hi;
    endtask

    initial begin
        int hi_cnt, lo_cnt, busy_cnt, guard, r0;

        // Power-on reset
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_all("por");

        // 1. Asynchronous reset mid-activity, between edges
        step("s1.pre", 1'b1, 1'b0);
        step("s1.pre", 1'b0, 1'b1 == 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("s1.async.pulse_hi", 32'(pulse_hi), 32'd0);
        check_eq("s1.async.pulse_lo", 32'(pulse_lo), 32'd1);
        check_eq("s1.async.busy", 32'(busy_hi), 32'd0);
        check_eq("s1.async.pend", 32'(pend_hi), 32'd0);
        check_eq("s1.async.ovf", 32'(ovf_hi), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        prev_pulse = 1'b0;
        for (int i = 0; i < 10; i++) step("s1.idle", 1'b0, 1'b0);

        // 2. Single event: 4 cycles high, 6 cycles busy (both polarities)
        hi_cnt = 0; lo_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step("s2", (i == 0), 1'b0);
            hi_cnt   += int'(pulse_hi);
            lo_cnt   += int'(!pulse_lo);
            busy_cnt += int'(busy_hi);
            if (i == 0) check_eq("s2.latency", 32'(pulse_hi), 32'd1);
        end
        check_eq("s2.width_hi", 32'(hi_cnt), 32'd4);
        check_eq("s2.width_lo", 32'(lo_cnt), 32'd4);
        check_eq("s2.busy_len", 32'(busy_cnt), 32'd6);

        // 3. Queued events: three pulses, no overflow
        r0 = rises;
        step("s3", 1'b1, 1'b0);
        step("s3", 1'b0, 1'b0);
        step("s3", 1'b1, 1'b0);
        step("s3", 1'b1, 1'b0);
        check_eq("s3.pend2", 32'(pend_hi), 32'd2);
        for (int i = 0; i < 16; i++) step("s3", 1'b0, 1'b0);
        check_eq("s3.pulses", 32'(rises - r0), 32'd3);
        check_eq("s3.ovf", 32'(ovf_hi), 32'd0);

        // 4. Overflow: pending saturates, exactly four pulses, overflow sticks
        r0 = rises;
        for (int i = 0; i < 5; i++) step("s4", 1'b1, 1'b0);
        check_eq("s4.pend_sat", 32'(pend_hi), 32'd3);
        check_eq("s4.ovf_set", 32'(ovf_hi), 32'd1);
        for (int i = 0; i < 30; i++) step("s4", 1'b0, 1'b0);
        check_eq("s4.pulses", 32'(rises - r0), 32'd4);
        check_eq("s4.ovf_sticky", 32'(ovf_hi), 32'd1);

        // 5a. Trigger on the last gap cycle with a full queue
        step("s5a.clr", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("s5a.fill", 1'b1, 1'b0);
        check_eq("s5a.full", 32'(pend_hi), 32'd3);
        guard = 0;
        while (m_since != H + G - 1 && guard < 20) begin
            step("s5a.wait", 1'b0, 1'b0);
            guard++;
        end
        check_eq("s5a.reach_gap_end", 32'(guard < 20), 32'd1);
        step("s5a.hit", 1'b1, 1'b0);
        check_eq("s5a.pend", 32'(pend_hi), 32'd3);
        check_eq("s5a.ovf", 32'(ovf_hi), 32'd0);
        check_eq("s5a.pulse", 32'(pulse_hi), 32'd1);

        // 5b. Trigger together with clear mid-pulse
        step("s5b", 1'b1, 1'b0);
        step("s5b", 1'b0, 1'b0);
        step("s5b.clr", 1'b1, 1'b1);
        check_eq("s5b.pulse_hi", 32'(pulse_hi), 32'd0);
        check_eq("s5b.pulse_lo", 32'(pulse_lo), 32'd1);
        check_eq("s5b.busy", 32'(busy_hi), 32'd0);
        check_eq("s5b.pend", 32'(pend_hi), 32'd0);
        check_eq("s5b.ovf", 32'(ovf_hi), 32'd0);
        r0 = rises;
        for (int i = 0; i < 8; i++) step("s5b.after", 1'b0, 1'b0);
        check_eq("s5b.no_pulse", 32'(rises - r0), 32'd0);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            step("rnd", ($urandom_range(0, 99) < 35), ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher_out.md
Name: pulse_stretcher_out

Overview:
Output-side counterpart to the push-button input conditioning. Converts single-cycle synchronous event pulses (e.g. edge-detector or UART status strobes) into clean, fixed-width pulses with guaranteed spacing, suitable for LEDs or slow external lines. Events arriving while a pulse is in flight are queued in a saturating pending counter and replayed back-to-back, so no event is silently merged.

Parameters:
HOLD_CYCLES, 200, active width of each output pulse in clk cycles; legal range 1..2^CNT_W-1.
GAP_CYCLES, 50, forced inactive cycles after each pulse; legal range 1..2^CNT_W-1.
CNT_W, 16, width of the shared hold/gap down-counter.
PEND_W, 4, width of the pending-event counter; saturates at 2^PEND_W-1.
ACTIVE_LOW, 0, 1 makes pulse_out active-low (inactive level = 1).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
trig_in  input  1  single-cycle event request, synchronous to clk
clear  input  1  synchronous flush: abort pulse, empty queue, clear overflow
pulse_out  output  1  stretched pulse, registered, polarity per ACTIVE_LOW
busy  output  1  1 whenever state != IDLE, registered
pending  output  PEND_W  queued events not yet started
overflow  output  1  sticky; an event was dropped because pending was full

Behaviour:
- Reset (reset_n=0, async): state=IDLE, counter=0, pulse_out=inactive level (0, or 1 if ACTIVE_LOW), busy=0, pending=0, overflow=0. Release is synchronous to clk.
- States: IDLE, ACTIVE, GAP.
- Start condition: start = trig_in | (pending != 0). It is evaluated in IDLE, and in GAP when counter==1 (last gap cycle).
- IDLE: on start, go to ACTIVE and load counter=HOLD_CYCLES. pulse_out goes active on the same edge.
  - Latency: trig_in sampled high at edge N gives pulse_out active in the cycle after edge N.
- ACTIVE: decrement the counter each cycle. When counter==1, go to GAP and load GAP_CYCLES; pulse_out goes inactive on that edge.
  - pulse_out is active for exactly HOLD_CYCLES cycles.
- GAP: decrement the counter each cycle; pulse_out is inactive.
  - When counter==1: on start, go directly to ACTIVE (reload HOLD_CYCLES); otherwise go to IDLE.
  - Queued pulses therefore repeat with a period of exactly HOLD_CYCLES+GAP_CYCLES.
- Queue arithmetic, applied on each edge:
  - consume = start taken while pending != 0. The oldest queued event is served first.
  - enqueue = trig_in and not (start taken in IDLE with pending==0).
  - pending_next = pending + enqueue - consume.
  - If enqueue and not consume and pending==max: the event is dropped, pending stays at max, overflow<=1.
  - enqueue and consume in the same cycle leave pending unchanged, even at max; no overflow.
- overflow stays set until clear or reset.
- clear (synchronous, highest priority after reset):
  - Next state is IDLE, counter=0, pulse_out inactive, busy=0, pending=0, overflow=0.
  - A trig_in in the same cycle as clear is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
Bench parameters: HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2 unless noted.
1. Reset: assert reset_n=0 mid-simulation with no clk edge -> pulse_out=0, busy=0, pending=0, overflow=0 immediately. Release, 10 idle cycles -> all outputs stay 0.
2. Single event: trig_in high for 1 cycle at edge N -> pulse_out=1 for exactly cycles N+1..N+4, then 0. busy=1 for cycles N+1..N+6, then 0 from N+7.
3. Queued events: triggers at N, N+2, N+3 -> pending goes 1 then 2. Three pulses start at N+1, N+7, N+13, each 4 cycles high. pending goes 2→1→0 at the starts. overflow stays 0.
4. Overflow: trigger at N, then trig_in held high for cycles N+1..N+4 -> pending saturates at 3 and overflow=1 at N+5. Exactly 4 pulses are emitted and overflow remains 1 afterwards.
5. Simultaneous events:
   - trig_in at the last GAP cycle with pending=3 -> next pulse starts, pending stays 3, overflow unchanged.
   - trig_in together with clear mid-pulse -> the next cycle has pulse_out=0, pending=0, overflow=0, busy=0, and no pulse follows.
6. Polarity: ACTIVE_LOW=1, repeat scenario 2 -> pulse_out idles at 1, is 0 for exactly 4 cycles, and returns to 1. Reset value is 1.
